prefix_add_pipe: RTL and testbench

//  Parametrised, pipelined Kogge-Stone prefix adder/subtractor with a valid/ready stream interface.
//  It is the successor to the combinational 16-bit prefix adder in the ALU.

---
 rtl/prefix_add_pipe_if.sv | 38 +++
 rtl/prefix_add_pipe.sv | 152 +++++++++++++++
 tb/tb_prefix_add_pipe.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/prefix_add_pipe_if.sv
// Valid/ready stream bundle for prefix_add_pipe.
// The ovf/zero flag signals exist only when PREFIX_ADD_FLAGS_EN is defined.
interface prefix_add_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             c_out;
`ifdef PREFIX_ADD_FLAGS_EN
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, x, y, c_in, sub, out_ready,
        input  in_ready, out_valid, s, c_out, ovf, zero
    );
    modport slave (
        input  in_valid, x, y, c_in, sub, out_ready,
        output in_ready, out_valid, s, c_out, ovf, zero
    );
`else
    modport master (
        output in_valid, x, y, c_in, sub, out_ready,
        input  in_ready, out_valid, s, c_out
    );
    modport slave (
        input  in_valid, x, y, c_in, sub, out_ready,
        output in_ready, out_valid, s, c_out
    );
`endif
endinterface

// File: rtl/prefix_add_pipe.sv
// Pipelined Kogge-Stone adder/subtractor, one prefix level per register stage.
// Optional signed-overflow and zero flags are enabled by defining PREFIX_ADD_FLAGS_EN.
module prefix_add_pipe #(
    parameter int WIDTH = 16
) (
    input logic              clk,
    input logic              rst,
    prefix_add_pipe_if.slave bus
);
    localparam int LEVELS = $clog2(WIDTH);

    logic             adv;
    logic [WIDTH-1:0] yy;
    logic             cc;

    logic [LEVELS-1:0]            valid_q;
    logic [LEVELS-1:0]            validStage_d;
    logic [LEVELS-1:0]            carryIn_q;
    logic [LEVELS-1:0]            carryStage_d;
    logic [LEVELS-1:0][WIDTH-1:0] gen_q;
    logic [LEVELS-1:0][WIDTH-1:0] genStage_d;
    logic [LEVELS-1:0][WIDTH-1:0] prop_q;
    logic [LEVELS-1:0][WIDTH-1:0] propStage_d;
    logic [LEVELS-1:0][WIDTH-1:0] halfSum_q;
    logic [LEVELS-1:0][WIDTH-1:0] halfStage_d;

    logic [LEVELS:1][WIDTH-1:0]   genLvl;
    logic [LEVELS:1][WIDTH-1:0]   propLvl;
    logic                         unusedTopProp;

    logic             outValid_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic             carryOut_q;
    logic             carryOut_d;

`ifdef PREFIX_ADD_FLAGS_EN
    logic [LEVELS-1:0] msbX_q;
    logic [LEVELS-1:0] msbStage_d;
    logic              ovf_q;
    logic              ovf_d;
    logic              zero_q;
    logic              zero_d;
`endif

    // Global stall: the whole pipe moves only when the output slot is free or draining.
    assign adv          = ~outValid_q | bus.out_ready;
    assign bus.in_ready = adv;

    assign yy = bus.sub ? ~bus.y : bus.y;
    assign cc = bus.sub | bus.c_in;

    // Carry-in is folded into bit 0's generate so the prefix tree needs no extra column.
    assign genStage_d[0]   = {bus.x[WIDTH-1:1] & yy[WIDTH-1:1],
                              (bus.x[0] & yy[0]) | (cc & (bus.x[0] | yy[0]))};
    assign propStage_d[0]  = bus.x ^ yy;
    assign halfStage_d[0]  = bus.x ^ yy;
    assign carryStage_d[0] = cc;
    assign validStage_d[0] = bus.in_valid;
`ifdef PREFIX_ADD_FLAGS_EN
    assign msbStage_d[0]   = bus.x[WIDTH-1];
`endif

    for (genvar j = 1; j <= LEVELS; j++) begin : gLevel
        localparam int D = 1 << (j - 1);
        for (genvar i = 0; i < WIDTH; i++) begin : gBit
            if (i >= D) begin : gMerge
                assign genLvl[j][i]  = gen_q[j-1][i] | (prop_q[j-1][i] & gen_q[j-1][i-D]);
                assign propLvl[j][i] = prop_q[j-1][i] & prop_q[j-1][i-D];
            end else begin : gPass
                assign genLvl[j][i]  = gen_q[j-1][i];
                assign propLvl[j][i] = prop_q[j-1][i];
            end
        end
        if (j < LEVELS) begin : gStage
            assign genStage_d[j]   = genLvl[j];
            assign propStage_d[j]  = propLvl[j];
            assign halfStage_d[j]  = halfSum_q[j-1];
            assign carryStage_d[j] = carryIn_q[j-1];
            assign validStage_d[j] = valid_q[j-1];
`ifdef PREFIX_ADD_FLAGS_EN
            assign msbStage_d[j]   = msbX_q[j-1];
`endif
        end
    end

    assign unusedTopProp = ^propLvl[LEVELS];

    always_comb begin
        sum_d      = halfSum_q[LEVELS-1] ^ {genLvl[LEVELS][WIDTH-2:0], carryIn_q[LEVELS-1]};
        carryOut_d = genLvl[LEVELS][WIDTH-1];
    end

`ifdef PREFIX_ADD_FLAGS_EN
    // Operand signs agree exactly when the stage-0 half-sum MSB is 0.
    always_comb begin
        ovf_d  = ~halfSum_q[LEVELS-1][WIDTH-1] & (sum_d[WIDTH-1] ^ msbX_q[LEVELS-1]);
        zero_d = ~|sum_d;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= '0;
            carryIn_q <= '0;
            gen_q     <= '0;
            prop_q    <= '0;
            halfSum_q <= '0;
`ifdef PREFIX_ADD_FLAGS_EN
            msbX_q    <= '0;
`endif
        end else if (adv) begin
            valid_q   <= validStage_d;
            carryIn_q <= carryStage_d;
            gen_q     <= genStage_d;
            prop_q    <= propStage_d;
            halfSum_q <= halfStage_d;
`ifdef PREFIX_ADD_FLAGS_EN
            msbX_q    <= msbStage_d;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outValid_q <= 1'b0;
            sum_q      <= '0;
            carryOut_q <= 1'b0;
`ifdef PREFIX_ADD_FLAGS_EN
            ovf_q      <= 1'b0;
            zero_q     <= 1'b0;
`endif
        end else if (adv) begin
            outValid_q <= valid_q[LEVELS-1];
            sum_q      <= sum_d;
            carryOut_q <= carryOut_d;
`ifdef PREFIX_ADD_FLAGS_EN
            ovf_q      <= ovf_d;
            zero_q     <= zero_d;
`endif
        end
    end

    assign bus.out_valid = outValid_q;
    assign bus.s         = sum_q;
    assign bus.c_out     = carryOut_q;
`ifdef PREFIX_ADD_FLAGS_EN
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
`endif

endmodule

// File: tb/tb_prefix_add_pipe.sv
// Bench for prefix_add_pipe: directed vectors at WIDTH=16, streaming/stall/reset sequences,
// and an exhaustive WIDTH=5 sweep. Flag checks are compiled in with PREFIX_ADD_FLAGS_EN.
module tb_prefix_add_pipe;
    localparam int W    = 16;
    localparam int LAT  = 4;
    localparam int W5   = 5;
    localparam int LAT5 = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    prefix_add_pipe_if #(.WIDTH(W))  bus ();
    prefix_add_pipe_if #(.WIDTH(W5)) bus5 ();

    prefix_add_pipe #(.WIDTH(W))  dut  (.clk(clk), .rst(rst), .bus(bus));
    prefix_add_pipe #(.WIDTH(W5)) dut5 (.clk(clk), .rst(rst), .bus(bus5));

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    vec_t vecs [12];
    int   total = 0;
    int   bad   = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain modulo add of the selected operand, independent of any prefix structure.
    function automatic logic [18:0] model16(input logic [15:0] x, input logic [15:0] y,
                                            input logic cin, input logic sub);
        logic [15:0] yv;
        logic [16:0] r;
        yv = sub ? ~y : y;
        r  = {1'b0, x} + {1'b0, yv} + {16'd0, (sub ? 1'b1 : cin)};
        return {(x[15] == yv[15]) && (r[15] != x[15]), r[15:0] == 16'd0, r};
    endfunction

    task automatic applyStimulus(input vec_t v, input int idx);
        @(negedge clk);
        bus.x        = v.x;
        bus.y        = v.y;
        bus.c_in     = v.cin;
        bus.sub      = v.sub;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (LAT - 1) @(negedge clk);
        checkOutput($sformatf("vec%0d early valid", idx), {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        checkOutput($sformatf("vec%0d valid", idx), {31'd0, bus.out_valid}, 32'd1);
        checkOutput($sformatf("vec%0d sum", idx), {15'd0, bus.c_out, bus.s}, {15'd0, v.cout, v.s});
`ifdef PREFIX_ADD_FLAGS_EN
        checkOutput($sformatf("vec%0d flags", idx), {30'd0, bus.ovf, bus.zero}, {30'd0, v.ovf, v.zero});
`endif
    endtask

    task automatic runStream(input int nOps, input int stallStart, input int stallLen,
                             input bit checkTiming, input string tag);
        logic [18:0] expQ[$];
        logic [18:0] e;
        int          sent;
        int          got;
        int          firstCyc;
        int          lastCyc;
        bit          pending;
        sent     = 0;
        got      = 0;
        firstCyc = -1;
        lastCyc  = -1;
        pending  = 1'b0;
        for (int c = 0; c < nOps + LAT + stallLen + 10; c++) begin
            @(negedge clk);
            bus.out_ready = !(c >= stallStart && c < stallStart + stallLen);
            if (!pending && sent < nOps) begin
                bus.x    = 16'($urandom);
                bus.y    = 16'($urandom);
                bus.c_in = 1'($urandom);
                bus.sub  = 1'($urandom);
                pending  = 1'b1;
            end
            bus.in_valid = pending;
            #1;
            if (bus.out_valid) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL %s extra result: got %0h expected none", tag, bus.s);
                end else if (bus.out_ready) begin
                    e = expQ.pop_front();
                    checkOutput($sformatf("%s result%0d", tag, got), {15'd0, bus.c_out, bus.s}, {15'd0, e[16:0]});
`ifdef PREFIX_ADD_FLAGS_EN
                    checkOutput($sformatf("%s flags%0d", tag, got), {30'd0, bus.ovf, bus.zero}, {30'd0, e[18:17]});
`endif
                    got++;
                    if (firstCyc < 0) firstCyc = c;
                    lastCyc = c;
                end else begin
                    checkOutput($sformatf("%s stalled sum", tag), {15'd0, bus.c_out, bus.s}, {15'd0, expQ[0][16:0]});
                    checkOutput($sformatf("%s in_ready under stall", tag), {31'd0, bus.in_ready}, 32'd0);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                expQ.push_back(model16(bus.x, bus.y, bus.c_in, bus.sub));
                sent++;
                pending = 1'b0;
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        checkOutput($sformatf("%s ops delivered", tag), got, nOps);
        if (checkTiming) begin
            checkOutput($sformatf("%s first latency", tag), firstCyc, 1 + LAT);
            checkOutput($sformatf("%s back-to-back span", tag), lastCyc - firstCyc, nOps - 1);
        end
    endtask

    // Ops stall at the output, then reset lands while a result is being held.
    task automatic resetMidStall();
        logic [18:0] e;
        int          stale;
        @(negedge clk);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.x        = 16'h1000 * 16'(k + 1);
            bus.y        = 16'h0011;
            bus.c_in     = 1'b0;
            bus.sub      = 1'b0;
            bus.in_valid = 1'b1;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        e = model16(16'h1000, 16'h0011, 1'b0, 1'b0);
        checkOutput("pre-reset valid", {31'd0, bus.out_valid}, 32'd1);
        checkOutput("pre-reset sum", {15'd0, bus.c_out, bus.s}, {15'd0, e[16:0]});
        rst = 1'b1;
        #1;
        checkOutput("async reset valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("async reset sum", {15'd0, bus.c_out, bus.s}, 32'd0);
`ifdef PREFIX_ADD_FLAGS_EN
        checkOutput("async reset flags", {30'd0, bus.ovf, bus.zero}, 32'd0);
`endif
        bus.x        = 16'h0101;
        bus.y        = 16'h0202;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        rst           = 1'b0;
        stale = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.out_valid) stale++;
        end
        checkOutput("stale results after reset", stale, 0);
    endtask

    task automatic sweepWidth5();
        logic [7:0] expQ[$];
        logic [7:0] e;
        logic [4:0] yv;
        logic [5:0] r;
        int         got;
        int         firstCyc;
        got      = 0;
        firstCyc = -1;
        bus5.out_ready = 1'b1;
        for (int c = 0; c < 4096 + LAT5 + 6; c++) begin
            @(negedge clk);
            if (c < 4096) begin
                bus5.x        = 5'(c);
                bus5.y        = 5'(c >> 5);
                bus5.c_in     = 1'(c >> 10);
                bus5.sub      = 1'(c >> 11);
                bus5.in_valid = 1'b1;
            end else begin
                bus5.in_valid = 1'b0;
            end
            #1;
            if (bus5.out_valid && expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput($sformatf("w5 op%0d", got), {26'd0, bus5.c_out, bus5.s}, {26'd0, e[5:0]});
`ifdef PREFIX_ADD_FLAGS_EN
                checkOutput($sformatf("w5 flags%0d", got), {30'd0, bus5.ovf, bus5.zero}, {30'd0, e[7:6]});
`endif
                if (firstCyc < 0) firstCyc = c;
                got++;
            end
            if (bus5.in_valid && bus5.in_ready) begin
                yv = bus5.sub ? ~bus5.y : bus5.y;
                r  = {1'b0, bus5.x} + {1'b0, yv} + {5'd0, (bus5.sub ? 1'b1 : bus5.c_in)};
                expQ.push_back({(bus5.x[4] == yv[4]) && (r[4] != bus5.x[4]), r[4:0] == 5'd0, r});
            end
        end
        bus5.in_valid = 1'b0;
        checkOutput("w5 ops delivered", got, 4096);
        checkOutput("w5 first latency", firstCyc, 1 + LAT5);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected test completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.x         = '0;
        bus.y         = '0;
        bus.c_in      = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        bus5.in_valid = 1'b0;
        bus5.x        = '0;
        bus5.y        = '0;
        bus5.c_in     = 1'b0;
        bus5.sub      = 1'b0;
        bus5.out_ready = 1'b1;

        //           x        y        cin   sub   s        cout  ovf   zero
        vecs[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{16'h0005, 16'h0005, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
        vecs[8]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{16'hAAAA, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0};

        repeat (2) @(negedge clk);
        checkOutput("reset valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("reset sum", {15'd0, bus.c_out, bus.s}, 32'd0);
`ifdef PREFIX_ADD_FLAGS_EN
        checkOutput("reset flags", {30'd0, bus.ovf, bus.zero}, 32'd0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 12; i++) applyStimulus(vecs[i], i);

        runStream(8, 0, 0, 1'b1, "stream");
        runStream(8, 7, 5, 1'b0, "stall");
        resetMidStall();
        sweepWidth5();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
